// File: rtl/sap_timing_pkg.sv
// Shared SAP-1 timing definitions: default ring length, T-state indices
// and a one-hot to binary index helper.
package sap_timing_pkg;

  localparam int NSTATES_DEFAULT = 6;

  // T-state indices (0 = T1)
  localparam logic [2:0] T1 = 3'd0;
  localparam logic [2:0] T2 = 3'd1;
  localparam logic [2:0] T3 = 3'd2;
  localparam logic [2:0] T4 = 3'd3;
  localparam logic [2:0] T5 = 3'd4;
  localparam logic [2:0] T6 = 3'd5;

  // Binary index of the set bit in a one-hot vector of up to 8 states.
  function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (oh[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/tstate_ring_if.sv
// Clock-enable / control inputs and T-state outputs of the timing ring.
// master = stimulus side (clock-enable generator, control decode),
// slave  = the ring itself.
interface tstate_ring_if #(
  parameter int NSTATES = 6,
  parameter int CW      = 3
);

  logic               clken;
  logic               clken2;
  logic               run;
  logic               step;
  logic               hlt;
  logic               early_end;
  logic [NSTATES-1:0] tstate;
  logic [CW-1:0]      tcount;
  logic               tadv;
  logic               mid_strobe;
  logic               halted;

  modport master (
    output clken, clken2, run, step, hlt, early_end,
    input  tstate, tcount, tadv, mid_strobe, halted
  );

  modport slave (
    input  clken, clken2, run, step, hlt, early_end,
    output tstate, tcount, tadv, mid_strobe, halted
  );

endinterface

// File: rtl/step_edge.sv
// Single-step request edge detector with a one-bit pending flag.
// The previous-step register is primed to 1 at reset so a button held
// through reset does not produce a step.
module step_edge (
  input  logic sysclk,
  input  logic reset,
  input  logic i_step,
  input  logic i_consume,
  output logic o_step_rise,
  output logic o_step_pending
);

  logic r_step_d;
  logic r_pending;

  assign o_step_rise    = i_step & ~r_step_d;
  assign o_step_pending = r_pending;

  // Track previous step level and latch one pending request.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_step_d  <= 1'b1;
      r_pending <= 1'b0;
    end else begin
      r_step_d <= i_step;
      if (i_consume) begin
        r_pending <= 1'b0;
      end else if (o_step_rise) begin
        r_pending <= 1'b1;
      end else begin
        r_pending <= r_pending;
      end
    end
  end

endmodule

// File: rtl/tstate_ring.sv
// SAP-1 T-state ring: one-hot T1..Tn timing advanced on slow-clock
// enables, with free-run / single-step, early termination and sticky halt.
module tstate_ring
  import sap_timing_pkg::*;
#(
  parameter int NSTATES = NSTATES_DEFAULT,
  parameter int CW      = 3
) (
  input  logic             sysclk,
  input  logic             reset,
  tstate_ring_if.slave     bus
);

  logic               w_step_rise;
  logic               w_step_pending;
  logic               w_go;
  logic               w_consume;
  logic [NSTATES-1:0] w_tstate_nxt;

  logic [NSTATES-1:0] r_tstate;
  logic [CW-1:0]      r_tcount;
  logic               r_tadv;
  logic               r_mid;
  logic               r_halted;
  logic               r_active;

  step_edge u_step_edge (
    .sysclk         (sysclk),
    .reset          (reset),
    .i_step         (bus.step),
    .i_consume      (w_consume),
    .o_step_rise    (w_step_rise),
    .o_step_pending (w_step_pending)
  );

  // Advance permission on a clken; run mode drains pending every clken.
  always_comb begin
    w_go      = 1'b0;
    w_consume = 1'b0;
    if (bus.clken) begin
      w_go      = ~r_halted & (bus.run | w_step_pending | w_step_rise);
      w_consume = bus.run | w_go;
    end else begin
      w_go      = 1'b0;
      w_consume = 1'b0;
    end
  end

  // Next one-hot T-state when an update is taken (early end returns to T1).
  always_comb begin
    w_tstate_nxt = r_tstate;
    if (bus.early_end) begin
      w_tstate_nxt = NSTATES'(1);
    end else begin
      w_tstate_nxt = {r_tstate[NSTATES-2:0], r_tstate[NSTATES-1]};
    end
  end

  // T-state, halt, period-active and strobe registers.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_tstate <= NSTATES'(1);
      r_tcount <= CW'(T1);
      r_tadv   <= 1'b0;
      r_mid    <= 1'b0;
      r_halted <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_tadv <= 1'b0;
      r_mid  <= 1'b0;
      if (bus.clken) begin
        if (w_go) begin
          r_active <= 1'b1;
          if (bus.hlt) begin
            r_halted <= 1'b1;
          end else begin
            r_tstate <= w_tstate_nxt;
            r_tcount <= CW'(onehot_to_idx(8'(w_tstate_nxt)));
            r_tadv   <= 1'b1;
          end
        end else begin
          r_active <= 1'b0;
        end
      end else if (bus.clken2 & ~r_halted & r_active) begin
        r_mid <= 1'b1;
      end else begin
        r_mid <= 1'b0;
      end
    end
  end

  assign bus.tstate     = r_tstate;
  assign bus.tcount     = r_tcount;
  assign bus.tadv       = r_tadv;
  assign bus.mid_strobe = r_mid;
  assign bus.halted     = r_halted;

endmodule

// File: tb/tb_tstate_ring.sv
// Bench for tstate_ring: hand-derived vector table, directed corner-case
// sequences and randomized periods checked against a behavioural model.
module tb_tstate_ring;
  import sap_timing_pkg::*;

  localparam int N  = 6;
  localparam int CW = 3;

  logic sysclk = 1'b0;
  logic reset  = 1'b0;

  tstate_ring_if #(.NSTATES(N), .CW(CW)) bus ();

  tstate_ring #(.NSTATES(N), .CW(CW)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int total = 0;
  int bad   = 0;
  bit g_junk = 1'b0;

  // behavioural model state
  int m_idx;
  bit m_halted, m_pend, m_stepd, m_active, m_tadv, m_mid;

  typedef struct packed {
    logic       rst_n, ck, ck2, run, step, hlt, ee;
    logic [5:0] ts;
    logic [2:0] tc;
    logic       tadv, mid, halt;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit rise, go;
    if (!reset) begin
      m_idx = 0; m_halted = 1'b0; m_pend = 1'b0; m_stepd = 1'b1;
      m_active = 1'b0; m_tadv = 1'b0; m_mid = 1'b0;
    end else begin
      rise   = bus.step && !m_stepd;
      m_tadv = 1'b0;
      m_mid  = 1'b0;
      if (bus.clken) begin
        go = !m_halted && (bus.run || m_pend || rise);
        if (go && bus.hlt) begin
          m_halted = 1'b1;
        end else if (go) begin
          m_idx  = bus.early_end ? 0 : (m_idx + 1) % N;
          m_tadv = 1'b1;
        end
        m_active = go;
        m_pend   = (bus.run || go) ? 1'b0 : (m_pend || rise);
      end else begin
        m_mid  = bus.clken2 && !m_halted && m_active;
        m_pend = m_pend || rise;
      end
      m_stepd = bus.step;
    end
  endtask

  task automatic cyc();
    @(posedge sysclk);
    model_step();
    @(negedge sysclk);
    chk("tstate", int'(bus.tstate), 1 << m_idx);
    chk("tcount", int'(bus.tcount), m_idx);
    chk("tadv", int'(bus.tadv), int'(m_tadv));
    chk("mid_strobe", int'(bus.mid_strobe), int'(m_mid));
    chk("halted", int'(bus.halted), int'(m_halted));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  // One slow period: clken at cycle 0, clken2 at the midpoint.
  task automatic period(input bit ee, input bit hl, input logic [15:0] spat, input int len);
    for (int c = 0; c < len; c++) begin
      bus.clken  = (c == 0);
      bus.clken2 = (c == len / 2);
      bus.step   = spat[c];
      if (c == 0) begin
        bus.early_end = ee;
        bus.hlt       = hl;
      end else begin
        bus.early_end = g_junk & ($urandom_range(0, 1) == 1);
        bus.hlt       = g_junk & ($urandom_range(0, 1) == 1);
      end
      cyc();
    end
    bus.clken     = 1'b0;
    bus.clken2    = 1'b0;
    bus.early_end = 1'b0;
    bus.hlt       = 1'b0;
  endtask

  initial begin
    bus.clken = 1'b0; bus.clken2 = 1'b0; bus.run = 1'b0;
    bus.step = 1'b0; bus.hlt = 1'b0; bus.early_end = 1'b0;

    // rst_n ck ck2 run step hlt ee | tstate | tcount | tadv mid halt
    tbl[0]  = {7'b0000000, 6'b000001, 3'd0, 3'b000};
    tbl[1]  = {7'b1101000, 6'b000010, 3'd1, 3'b100};
    tbl[2]  = {7'b1011000, 6'b000010, 3'd1, 3'b010};
    tbl[3]  = {7'b1001000, 6'b000010, 3'd1, 3'b000};
    tbl[4]  = {7'b1101001, 6'b000001, 3'd0, 3'b100};
    tbl[5]  = {7'b1100000, 6'b000001, 3'd0, 3'b000};
    tbl[6]  = {7'b1010000, 6'b000001, 3'd0, 3'b000};
    tbl[7]  = {7'b1000100, 6'b000001, 3'd0, 3'b000};
    tbl[8]  = {7'b1100100, 6'b000010, 3'd1, 3'b100};
    tbl[9]  = {7'b1100000, 6'b000010, 3'd1, 3'b000};
    tbl[10] = {7'b1101010, 6'b000010, 3'd1, 3'b001};
    tbl[11] = {7'b1101000, 6'b000010, 3'd1, 3'b001};
    tbl[12] = {7'b1011000, 6'b000010, 3'd1, 3'b001};
    tbl[13] = {7'b0000000, 6'b000001, 3'd0, 3'b000};

    for (int i = 0; i < 14; i++) begin
      reset = tbl[i].rst_n; bus.clken = tbl[i].ck; bus.clken2 = tbl[i].ck2;
      bus.run = tbl[i].run; bus.step = tbl[i].step; bus.hlt = tbl[i].hlt;
      bus.early_end = tbl[i].ee;
      @(posedge sysclk);
      model_step();
      @(negedge sysclk);
      chk("vec_tstate", int'(bus.tstate), int'(tbl[i].ts));
      chk("vec_tcount", int'(bus.tcount), int'(tbl[i].tc));
      chk("vec_tadv", int'(bus.tadv), int'(tbl[i].tadv));
      chk("vec_mid", int'(bus.mid_strobe), int'(tbl[i].mid));
      chk("vec_halted", int'(bus.halted), int'(tbl[i].halt));
    end
    reset = 1'b1; bus.clken = 1'b0; bus.clken2 = 1'b0;
    bus.run = 1'b0; bus.step = 1'b0; bus.hlt = 1'b0; bus.early_end = 1'b0;

    // free run with the divide-by-8 enable pattern, wraps past T6
    do_reset();
    bus.run = 1'b1;
    repeat (7) period(1'b0, 1'b0, 16'h0000, 8);
    chk("wrap_T2", int'(bus.tcount), 1);

    // early end at T3 goes back to T1
    do_reset();
    repeat (2) period(1'b0, 1'b0, 16'h0000, 8);
    period(1'b1, 1'b0, 16'h0000, 8);
    chk("early_T3", int'(bus.tcount), 0);

    // single-step: idle periods, then four edges give one advance
    do_reset();
    bus.run = 1'b0;
    repeat (5) period(1'b0, 1'b0, 16'h0000, 8);
    chk("step_idle", int'(bus.tcount), 0);
    period(1'b0, 1'b0, 16'h00AA, 8);
    period(1'b0, 1'b0, 16'h0000, 8);
    period(1'b0, 1'b0, 16'h0000, 8);
    chk("single_step", int'(bus.tcount), 1);

    // step edge coincident with clken advances and leaves nothing pending
    period(1'b0, 1'b0, 16'h0001, 8);
    period(1'b0, 1'b0, 16'h0000, 8);
    chk("step_on_clken", int'(bus.tcount), 2);

    // hlt beats early_end at T4; halt is sticky until reset
    do_reset();
    bus.run = 1'b1;
    repeat (3) period(1'b0, 1'b0, 16'h0000, 8);
    period(1'b1, 1'b1, 16'h0000, 8);
    chk("halt_set", int'(bus.halted), 1);
    period(1'b1, 1'b0, 16'h0055, 8);
    bus.run = 1'b0;
    period(1'b0, 1'b0, 16'h0055, 8);
    chk("halt_hold", int'(bus.tcount), 3);
    do_reset();
    chk("halt_clear", int'(bus.halted), 0);

    // reset mid-period at T5 with a step pending
    bus.run = 1'b1;
    repeat (4) period(1'b0, 1'b0, 16'h0000, 8);
    bus.run = 1'b0;
    bus.step = 1'b1; cyc();
    bus.step = 1'b0; cyc();
    bus.clken2 = 1'b1;
    do_reset();
    bus.clken2 = 1'b0;
    chk("rst_T1", int'(bus.tcount), 0);
    chk("rst_mid", int'(bus.mid_strobe), 0);
    cyc();
    period(1'b0, 1'b0, 16'h0000, 8);
    chk("pend_cleared", int'(bus.tcount), 0);
    bus.run = 1'b1;
    period(1'b0, 1'b0, 16'h0000, 8);
    chk("resume", int'(bus.tcount), 1);

    // randomized periods against the model
    g_junk = 1'b1;
    for (int k = 0; k < 200; k++) begin
      bus.run = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 19) == 0) begin
        do_reset();
      end
      period(($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
             16'($urandom), $urandom_range(4, 10));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
